// File: rtl/pwm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : pwm_pkg
// Shared constants, one-hot state encoding and command decode for the
// half-bridge dead-time stage.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_DT_W = 8;
  localparam logic [PWM_DT_W-1:0] PWM_DT_DEFAULT = 8'd16;

  localparam int ST_W = 6;

  localparam int ST_OFF_B  = 0;
  localparam int ST_DTH_B  = 1;
  localparam int ST_DTL_B  = 2;
  localparam int ST_HON_B  = 3;
  localparam int ST_LON_B  = 4;
  localparam int ST_FLT_B  = 5;

  // One-hot so every gate output is a single flop with no decode glitch.
  localparam logic [ST_W-1:0] ST_OFF     = 6'b000001;
  localparam logic [ST_W-1:0] ST_DT_TO_H = 6'b000010;
  localparam logic [ST_W-1:0] ST_DT_TO_L = 6'b000100;
  localparam logic [ST_W-1:0] ST_H_ON    = 6'b001000;
  localparam logic [ST_W-1:0] ST_L_ON    = 6'b010000;
  localparam logic [ST_W-1:0] ST_FAULT   = 6'b100000;

  typedef enum logic [1:0] {
    CMD_OFF = 2'd0,
    CMD_H   = 2'd1,
    CMD_L   = 2'd2
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic h, input logic l);
    if (h && !l) return CMD_H;
    if (l && !h) return CMD_L;
    return CMD_OFF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_deadtime_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : pwm_deadtime_gen_if
// Command, configuration, fault and gate-drive bundle of the dead-time stage.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface pwm_deadtime_gen_if #(
  parameter int DT_W = pwm_pkg::PWM_DT_W
);

  logic            en;
  logic            h_in;
  logic            l_in;
  logic [DT_W-1:0] dt_cycles;
  logic            fault;
  logic            fault_clr;
  logic            h_gate;
  logic            l_gate;
  logic            dt_busy;
  logic            fault_flag;
  logic            illegal_flag;

  modport master (
    output en, h_in, l_in, dt_cycles, fault, fault_clr,
    input  h_gate, l_gate, dt_busy, fault_flag, illegal_flag
  );

  modport slave (
    input  en, h_in, l_in, dt_cycles, fault, fault_clr,
    output h_gate, l_gate, dt_busy, fault_flag, illegal_flag
  );

endinterface
`default_nettype wire

// File: rtl/pwm_fault_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pwm_fault_sync
// Two-flop synchroniser for asynchronous bridge inputs.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module pwm_fault_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pwm_deadtime_gen
// Dead-time insertion FSM with illegal-command and latched-fault handling.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W
) (
  input  logic              clk,
  input  logic              rst,
  pwm_deadtime_gen_if.slave bus
);

  logic [ST_W-1:0] state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            fault_s;
  logic [DT_W-1:0] dt_load;
  cmd_t            cmd;

  pwm_fault_sync #(
    .WIDTH (1)
  ) u_fault_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (bus.fault),
    .q_out (fault_s)
  );

  assign dt_load = DT_W'(bus.dt_cycles);
  assign cmd     = decode_cmd(bus.h_in, bus.l_in);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_s) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (bus.fault_clr) state_d = ST_OFF;
    end else if (!bus.en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF, ST_H_ON, ST_L_ON: begin
          if (cmd == CMD_H && state_q != ST_H_ON) begin
            state_d = ST_DT_TO_H;
            cnt_d   = dt_load;
          end else if (cmd == CMD_L && state_q != ST_L_ON) begin
            state_d = ST_DT_TO_L;
            cnt_d   = dt_load;
          end else if (cmd == CMD_OFF) begin
            state_d = ST_OFF;
          end
        end
        ST_DT_TO_H: begin
          if (cmd == CMD_H) begin
            if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
            else             state_d = ST_H_ON;
          end else if (cmd == CMD_L) begin
            // An aborted interval restarts in full for the other side.
            state_d = ST_DT_TO_L;
            cnt_d   = dt_load;
          end else begin
            state_d = ST_OFF;
          end
        end
        ST_DT_TO_L: begin
          if (cmd == CMD_L) begin
            if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
            else             state_d = ST_L_ON;
          end else if (cmd == CMD_H) begin
            state_d = ST_DT_TO_H;
            cnt_d   = dt_load;
          end else begin
            state_d = ST_OFF;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    illegal_d = (illegal_q & ~bus.fault_clr) | (bus.h_in & bus.l_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.h_gate       = state_q[ST_HON_B];
  assign bus.l_gate       = state_q[ST_LON_B];
  assign bus.dt_busy      = state_q[ST_DTH_B] | state_q[ST_DTL_B];
  assign bus.fault_flag   = state_q[ST_FLT_B];
  assign bus.illegal_flag = illegal_q;

endmodule
`default_nettype wire

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Dead-time insertion stage placed directly downstream of the half-bridge PWM core. It takes the core's complementary high/low commands and drives the two gate outputs. It guarantees a programmable all-off interval on every commutation, suppresses illegal commands, and latches a hardware fault that forces both gates off until software clears it.

## Interface
- DT_W, 8, width of the dead-time count
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  bridge enable; low forces both gates off
- h_in  in  1  high-side command from the PWM core
- l_in  in  1  low-side command from the PWM core
- dt_cycles  in  DT_W  dead-time setting; both-off interval is dt_cycles+1 clk cycles
- fault  in  1  asynchronous external fault, active-high
- fault_clr  in  1  one-cycle pulse that clears the fault latch and illegal_flag
- h_gate  out  1  high-side gate drive
- l_gate  out  1  low-side gate drive
- dt_busy  out  1  high while a dead-time interval is running
- fault_flag  out  1  high while in FAULT
- illegal_flag  out  1  sticky; set when h_in=l_in=1 is sampled

## Operation
- Command decode:
  - H when h_in&~l_in.
  - L when l_in&~h_in.
  - OFF otherwise.
  - h_in=l_in=1 also sets illegal_flag.
- States: OFF, DT_TO_H, DT_TO_L, H_ON, L_ON, FAULT. Gate outputs are decoded directly from state flops:
  - h_gate=(H_ON)
  - l_gate=(L_ON)
  - dt_busy=(DT_TO_H|DT_TO_L)
  - fault_flag=(FAULT)
- Transition priority: rst > fault_s > ~en > command.
- Transitions from OFF:
  - Command H: go to DT_TO_H and load cnt=dt_cycles.
  - Command L: go to DT_TO_L and load cnt=dt_cycles.
- Behaviour in DT_TO_X:
  - Command still X and cnt≠0: cnt decrements by 1.
  - Command still X and cnt==0: go to X_ON.
  - Command becomes the opposite side: go to the other DT state and reload cnt=dt_cycles. Every commutation gets a full dead time.
  - Command becomes OFF: go to OFF.
- Behaviour in H_ON:
  - Command L: go to DT_TO_L and load cnt.
  - Command OFF: go to OFF.
  - L_ON is symmetric.
- en=0 in any state except FAULT: go to OFF next edge. When en returns, the cycle restarts through a DT state.
- fault path:
  - fault is synchronised by two flops to give fault_s.
  - fault_s=1 moves any state to FAULT.
  - FAULT exits to OFF only on fault_clr=1 with fault_s=0. fault_clr while fault_s=1 is ignored.
- fault_clr also clears illegal_flag, in any state.
- dt_cycles is sampled only at DT state entry. Changes mid-interval take effect at the next commutation.
- cnt is DT_W bits and only decrements while nonzero, so no wrap-around.

## Timing
- Reset values: state=OFF, cnt=0, sync flops=0. All outputs 0.
- Gate turn-off latency: a command change sampled at edge n drops the active gate at edge n (registered, visible in the following cycle).
- Dead time: the opposite gate rises at edge n+dt_cycles+1.
  - Both gates are low for exactly dt_cycles+1 cycles.
  - Minimum is 1 cycle at dt_cycles=0.
- Fault latency: fault asserted before edge a gives gates low after edge a+2.
- Both gates are never high in the same cycle, under any input sequence, including rst mid-operation.
- Mid-operation rst returns everything to reset values on the next edge.

## Structure
- Shared package pwm_pkg:
  - State encoding localparams. One-hot is preferred so gates decode from a single flop.
  - DT_W default.
  - The dead-time default constant used by the integration top.
- Sub-module pwm_fault_sync: 2-flop synchroniser. It is reused for other asynchronous bridge inputs.
- The FSM and the counter stay in pwm_deadtime_gen.

## Test plan
- Reset: rst=1 for 3 cycles with h_in=1 and en=1 -> h_gate=l_gate=dt_busy=fault_flag=illegal_flag=0; state OFF after rst release.
- Commutation, dt_cycles=5, en=1:
  - h_in=1/l_in=0 sampled at edge n -> h_gate rises after edge n+6.
  - Command flips to L at edge m -> h_gate low after m, l_gate high after m+6.
  - Never both high.
- Abort, dt_cycles=10: H_ON -> L command for 3 cycles -> back to H -> l_gate never asserts; h_gate rises 11 edges after the return.
- dt_cycles=0 with alternating commands every 8 cycles -> exactly 1 both-low cycle per transition.
- Fault handling:
  - 1-cycle fault pulse during H_ON -> h_gate low after 3 edges; fault_flag=1 and stays 1.
  - fault_clr while fault is held high -> no effect.
  - fault low then fault_clr -> OFF, then full 6-cycle dead time before the next gate rises (dt_cycles=5).
- Illegal command: h_in=l_in=1 from H_ON -> gates off, illegal_flag=1 and sticky; cleared by fault_clr.
